// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, word bit positions and command codes for the LCD driver
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_RS_BIT = 8;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter that parks at zero and reports current/next zero
module lcd_timer #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_zero,
  output logic          o_next_zero
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_zero      = (r_cnt == '0);
  assign o_next_zero = (w_cnt_nxt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - write-only HD44780 bus driver: one handshaked word per setup/pulse/hold/exec cycle
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 25,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000,
  parameter int LONG_CYC  = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lcd_word,
  input  logic        i_lcd_vld,
  output logic        o_lcd_rdy,
  output logic        o_lcd_done,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_ON
);

  localparam int CW = $clog2(LONG_CYC + 1);

  localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] C_EN    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] C_EXEC  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] C_LONG  = CW'(LONG_CYC - 1);

  if (SETUP_CYC < 1 || EN_CYC < 1 || HOLD_CYC < 1 || EXEC_CYC < 1 || LONG_CYC < EXEC_CYC)
  begin : g_param_check
    $error("lcd_ctrl: timing parameters out of range");
  end

  lcd_state_e    r_state;
  lcd_state_e    w_state_nxt;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_zero;
  logic          w_next_zero;
  logic          w_accept;
  logic          w_long_word;
  logic [7:0]    w_byte;
  logic          r_long;
  logic [7:0]    r_data;
  logic          r_rs;
  logic          r_on;
  logic          r_en;
  logic          r_done;
  logic          w_unused;

  assign w_unused = ^i_lcd_word[30:9];

  assign w_byte      = i_lcd_word[7:0];
  assign w_accept    = (r_state == IDLE) && i_lcd_vld;
  // Clear and both return-home encodings need the long execution wait.
  assign w_long_word = !i_lcd_word[LCD_RS_BIT] &&
                       ((w_byte == LCD_CMD_CLEAR) || (w_byte[7:1] == LCD_CMD_HOME[7:1]));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      IDLE: begin
        if (i_lcd_vld) begin
          w_state_nxt = SETUP;
          w_load      = 1'b1;
          w_load_val  = C_SETUP;
        end
      end
      SETUP: begin
        if (w_zero) begin
          w_state_nxt = PULSE;
          w_load      = 1'b1;
          w_load_val  = C_EN;
        end
      end
      PULSE: begin
        if (w_zero) begin
          w_state_nxt = HOLD;
          w_load      = 1'b1;
          w_load_val  = C_HOLD;
        end
      end
      HOLD: begin
        if (w_zero) begin
          w_state_nxt = WAIT;
          w_load      = 1'b1;
          w_load_val  = r_long ? C_LONG : C_EXEC;
        end
      end
      WAIT: begin
        if (w_zero) begin
          w_state_nxt = IDLE;
          w_load      = 1'b1;
          w_load_val  = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_load      = 1'b1;
        w_load_val  = '0;
      end
    endcase
  end

  lcd_timer #(
    .CW(CW)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .o_zero      (w_zero),
    .o_next_zero (w_next_zero)
  );

  // EN and done are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_long  <= 1'b0;
      r_data  <= '0;
      r_rs    <= 1'b0;
      r_on    <= 1'b0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= (w_state_nxt == PULSE);
      r_done  <= (w_state_nxt == WAIT) && w_next_zero;
      if (w_accept) begin
        r_data <= w_byte;
        r_rs   <= i_lcd_word[LCD_RS_BIT];
        r_on   <= i_lcd_word[LCD_ON_BIT];
        r_long <= w_long_word;
      end
    end
  end

  assign o_lcd_rdy  = (r_state == IDLE);
  assign o_lcd_done = r_done;
  assign LCD_DATA   = r_data;
  assign LCD_RS     = r_rs;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = r_en;
  assign LCD_ON     = r_on;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - scoreboard bench for lcd_ctrl with short timing parameters
module tb_lcd_ctrl;

  localparam int S = 2;
  localparam int E = 3;
  localparam int H = 1;
  localparam int X = 5;
  localparam int L = 20;

  typedef struct {
    logic [31:0] word;
    int          ret;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lcd_word = '0;
  logic        lcd_vld = 1'b0;
  logic        lcd_rdy;
  logic        lcd_done;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  sb_item_t sb[$];

  bit          m_act = 1'b0;
  int          m_k = 0;
  int          m_ret = 0;
  logic [31:0] m_word = '0;

  lcd_ctrl #(
    .SETUP_CYC (S),
    .EN_CYC    (E),
    .HOLD_CYC  (H),
    .EXEC_CYC  (X),
    .LONG_CYC  (L)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_lcd_word (lcd_word),
    .i_lcd_vld  (lcd_vld),
    .o_lcd_rdy  (lcd_rdy),
    .o_lcd_done (lcd_done),
    .LCD_DATA   (lcd_data),
    .LCD_RS     (lcd_rs),
    .LCD_RW     (lcd_rw),
    .LCD_EN     (lcd_en),
    .LCD_ON     (lcd_on)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Monitor: timing of each transfer is judged relative to the cycle its handshake was seen.
  always @(negedge clk) begin
    sb_item_t it;
    int rel;
    if (!rst_n) begin
      m_act = 1'b0;
    end else begin
      if (m_act) begin
        rel = cyc - m_k;
        chk("en",   lcd_en,   (rel >= 1 + S && rel < 1 + S + E));
        chk("done", lcd_done, (rel == m_ret - 1));
        chk("rdy",  lcd_rdy,  (rel == m_ret));
        chk("data", lcd_data, m_word[7:0]);
        chk("rs",   lcd_rs,   m_word[8]);
        chk("on",   lcd_on,   m_word[31]);
        chk("rw",   lcd_rw,   1'b0);
        if (rel >= m_ret) m_act = 1'b0;
      end else begin
        chk("idle_en",   lcd_en,   1'b0);
        chk("idle_done", lcd_done, 1'b0);
        chk("idle_rdy",  lcd_rdy,  1'b1);
      end
      if (lcd_vld && lcd_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_accept", 1, 0);
        end else begin
          it     = sb.pop_front();
          m_act  = 1'b1;
          m_k    = cyc;
          m_word = it.word;
          m_ret  = it.ret;
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input int ret, input bit hold);
    bit got;
    sb.push_back('{word: w, ret: ret});
    lcd_word = w;
    lcd_vld  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lcd_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) lcd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lcd_rdy && !m_act) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_rs",   lcd_rs,   1'b0);
    chk("rst_en",   lcd_en,   1'b0);
    chk("rst_on",   lcd_on,   1'b0);
    chk("rst_rw",   lcd_rw,   1'b0);
    chk("rst_done", lcd_done, 1'b0);
    chk("rst_rdy",  lcd_rdy,  1'b1);
    repeat (10) @(posedge clk);
    #1;

    send(32'h8000_0141, 1 + S + E + H + X, 1'b0);
    wait_idle();
    send(32'h8000_0001, 1 + S + E + H + L, 1'b0);
    wait_idle();
    send(32'h8000_0038, 1 + S + E + H + X, 1'b0);
    wait_idle();
    send(32'h0000_0002, 1 + S + E + H + L, 1'b0);
    send(32'h8000_0003, 1 + S + E + H + L, 1'b0);
    send(32'h8000_0103, 1 + S + E + H + X, 1'b0);
    send(32'h0000_0000, 1 + S + E + H + X, 1'b0);
    wait_idle();

    send(32'h8000_0161, 1 + S + E + H + X, 1'b1);
    send(32'h8000_0162, 1 + S + E + H + X, 1'b1);
    send(32'h8000_0163, 1 + S + E + H + X, 1'b0);
    wait_idle();

    send(32'h8000_0142, 1 + S + E + H + X, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    lcd_word = 32'h8000_0155;
    lcd_vld  = 1'b1;
    @(posedge clk);
    #1;
    lcd_vld  = 1'b0;
    wait_idle();

    send(32'h8000_0144, 1 + S + E + H + X, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (lcd_en) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("en_timeout", 0, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_en",   lcd_en,   1'b0);
    chk("mid_rst_on",   lcd_on,   1'b0);
    chk("mid_rst_done", lcd_done, 1'b0);
    chk("mid_rst_rdy",  lcd_rdy,  1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h8000_0145, 1 + S + E + H + X, 1'b0);
    wait_idle();
    repeat (3) @(posedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Write-only HD44780 character-LCD bus driver for the DE2 board top level. It accepts command/data words from the core's LCD I/O register through a valid/ready handshake. Each word is serialised onto LCD_DATA/LCD_RS/LCD_EN with the controller's setup, enable-pulse, hold and execution timing. The block is the transmitting end of the LCD interface that TOP_SYNTH exposes as LCD_DATA, LCD_RW, LCD_EN, LCD_RS and LCD_ON.

## Interface
- SETUP_CYC, 4: cycles RS/DATA stable before EN rises (80 ns @ 50 MHz); must be ≥1.
- EN_CYC, 25: cycles EN held high (500 ns); must be ≥1.
- HOLD_CYC, 2: cycles after EN falls before the execution wait; must be ≥1.
- EXEC_CYC, 2000: execution wait for ordinary commands and data (40 µs); must be ≥1.
- LONG_CYC, 82000: execution wait for clear (0x01) and return-home (0x02/0x03) commands (1.64 ms); must be ≥ EXEC_CYC.
- i_clk  in  1  system clock (CLOCK_50 domain).
- i_rst_n  in  1  reset. Synchronous, active-low.
- i_lcd_word  in  32  request word: [31] LCD_ON, [8] RS (0 = command, 1 = data), [7:0] byte; other bits ignored.
- i_lcd_vld  in  1  request valid.
- o_lcd_rdy  out  1  block idle; a request is accepted on a cycle where i_lcd_vld && o_lcd_rdy.
- o_lcd_done  out  1  one-cycle pulse when a transfer's execution wait completes.
- LCD_DATA  out  8  LCD data bus.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  constant 0 (write-only).
- LCD_EN  out  1  enable strobe.
- LCD_ON  out  1  backlight/power enable.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
- IDLE:
  - o_lcd_rdy = 1; this is the only state with ready high.
  - On accept, register LCD_DATA ← word[7:0], LCD_RS ← word[8] and LCD_ON ← word[31].
  - Register long = (RS==0 && byte[7:1]==7'b0000000 && byte!=0), i.e. byte 0x01–0x03.
  - Go to SETUP.
- SETUP: EN=0 for SETUP_CYC cycles → PULSE.
- PULSE: EN=1 for EN_CYC cycles → HOLD.
- HOLD: EN=0 for HOLD_CYC cycles → WAIT.
- WAIT:
  - Lasts LONG_CYC cycles if long is set, else EXEC_CYC cycles.
  - On the last cycle, assert o_lcd_done; the next state is IDLE.
- LCD_DATA, LCD_RS and LCD_ON hold their values from accept until the next accept; they never change while EN=1.
- i_lcd_vld when not ready: ignored. The requester must hold the word until accept; no buffering.
- One shared down-counter, width $clog2(LONG_CYC+1). It is loaded with (duration−1) on each state entry; the state advances when the counter is 0.

## Timing
- Reset (synchronous, next edge with i_rst_n=0):
  - State IDLE, counter 0, long 0.
  - LCD_DATA=0, LCD_RS=0, LCD_EN=0, LCD_ON=0, LCD_RW=0, o_lcd_done=0.
  - o_lcd_rdy=1 from the first cycle after reset.
- Reset mid-transfer aborts at the next edge: EN drops immediately with no completion pulse, and LCD_ON is cleared.
- Accept at edge k:
  - Outputs update at edge k+1, and o_lcd_rdy is 0 from k+1.
  - EN rises at edge k+1+SETUP_CYC and falls EN_CYC cycles later.
  - o_lcd_done is high during the final WAIT cycle.
  - o_lcd_rdy returns at edge k+1+SETUP_CYC+EN_CYC+HOLD_CYC+wait.
- Back-to-back operation: with i_lcd_vld held high, the next accept occurs in the first IDLE cycle, so there is no dead cycle beyond the one IDLE cycle.
- o_lcd_rdy is combinational from state; o_lcd_done and all LCD_* outputs are registered.

## Structure
- lcd_pkg holds:
  - the state enum lcd_state_e;
  - bit-position constants LCD_ON_BIT=31 and LCD_RS_BIT=8;
  - command constants LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME=8'h02.
- A single sub-module, lcd_timer, holds the loadable down-counter with a zero flag. The FSM and output registers stay in lcd_ctrl.
- Parameter sanity (all ≥1, LONG_CYC ≥ EXEC_CYC) is checked by an initial assertion.

## Test plan
All scenarios use SETUP_CYC=2, EN_CYC=3, HOLD_CYC=1, EXEC_CYC=5, LONG_CYC=20.
- **Reset:** hold i_rst_n=0 for 3 cycles, then release → all LCD_* outputs 0 and o_lcd_rdy=1. Drive i_lcd_vld=0 for 10 cycles → no EN activity.
- **Data write:** accept word 0x8000_0141 → at k+1, LCD_ON=1, RS=1, DATA=0x41. EN high exactly during cycles k+3..k+5. o_lcd_done is pulsed once and o_lcd_rdy returns at k+12 (busy 11 cycles).
- **Clear command:** accept 0x8000_0001 → RS=0, DATA=0x01, and the WAIT lasts 20 cycles, so rdy returns at k+27. Repeat with byte 0x38 → rdy returns at k+12.
- **Back-to-back:** hold i_lcd_vld=1 across three data words → three EN pulses with DATA stable during each. Each accept occurs on the first rdy cycle, and rdy is never high for more than one cycle.
- **Ignored request:** pulse i_lcd_vld with 0x8000_0155 while busy → no change to DATA/RS and no extra EN pulse.
- **Mid-transfer reset:** assert i_rst_n=0 while EN=1 → EN=0 and LCD_ON=0 after the next edge, with no o_lcd_done pulse. The first request after release completes normally.
